// File: rtl/load_store_unit.sv
// Load/store stage behind the ALU: one handshaked word access per request,
// with lane steering for stores and sign/zero extension for loads.
module load_store_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_load,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [WIDTH-1:0] rd_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

  state_t           state_q;
  logic             is_load_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic             busy_q, done_q, fault_q, mem_req_q, mem_we_q;
  logic [WIDTH-1:0] rd_data_q, mem_addr_q, mem_wdata_q;
  logic [3:0]       mem_wmask_q;

  logic             illegal_d;
  logic [WIDTH-1:0] wdata_d;
  logic [3:0]       wmask_d;
  logic [WIDTH-1:0] load_d;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;

  // Request legality: exactly one of load/store, a supported size, natural alignment.
  always_comb begin
    illegal_d = 1'b0;
    if (is_load == is_store)
      illegal_d = 1'b1;
    else if (is_store && !(funct3 inside {3'b000, 3'b001, 3'b010}))
      illegal_d = 1'b1;
    else if (is_load && (funct3 inside {3'b011, 3'b110, 3'b111}))
      illegal_d = 1'b1;
    if (funct3[1:0] == 2'b01 && addr[0])
      illegal_d = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
      illegal_d = 1'b1;
  end

  // Store lane replication and byte enables; reads carry no mask.
  always_comb begin
    wdata_d = '0;
    wmask_d = 4'b0000;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wdata_d = {4{rs2_data[7:0]}};
          wmask_d = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          wdata_d = {2{rs2_data[15:0]}};
          wmask_d = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_d = rs2_data;
          wmask_d = 4'b1111;
        end
      endcase
    end
  end

  // Load extraction from the returned word using the latched offset and size.
  always_comb begin
    byte_c = mem_rdata[BYTE_W*off_q +: BYTE_W];
    half_c = mem_rdata[HALF_W*off_q[1] +: HALF_W];
    case (funct3_q)
      3'b000:  load_d = {{(WIDTH-BYTE_W){byte_c[7]}}, byte_c};
      3'b001:  load_d = {{(WIDTH-HALF_W){half_c[15]}}, half_c};
      3'b100:  load_d = {{(WIDTH-BYTE_W){1'b0}}, byte_c};
      3'b101:  load_d = {{(WIDTH-HALF_W){1'b0}}, half_c};
      default: load_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rd_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            is_load_q  <= is_load;
            funct3_q   <= funct3;
            off_q      <= addr[1:0];
            mem_addr_q <= {addr[WIDTH-1:2], 2'b00};
            if (illegal_d) begin
              state_q <= FAULT;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q     <= REQ;
              busy_q      <= 1'b1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_wdata_q <= wdata_d;
              mem_wmask_q <= wmask_d;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            state_q     <= RESP;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            fault_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= 4'b0000;
            if (is_load_q)
              rd_data_q <= load_d;
          end
        end
        RESP: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        FAULT: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign rd_data   = rd_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver queues expected memory
// requests and completions, a memory responder and a done monitor check them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, rs2_data;
  logic        busy, done, fault;
  logic [31:0] rd_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  load_store_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .rs2_data(rs2_data), .busy(busy), .done(done),
    .fault(fault), .rd_data(rd_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          cyc;
  } req_t;

  typedef struct {
    logic        fault;
    logic [31:0] rd;
    int          cyc;
  } resp_t;

  req_t        req_q[$];
  resp_t       resp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat_cfg = 1;
  logic [31:0] rdata_cfg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: checks each request, holds ready low lat_cfg-1 cycles.
  initial begin : responder
    req_t        e;
    logic        ok, aborted;
    logic        we0;
    logic [31:0] a0, w0;
    logic [3:0]  m0;
    int          lat;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req && !mem_ready) begin
        lat = lat_cfg;
        if (req_q.size() == 0) begin
          check("unexpected_mem_req", 32'(mem_req), 32'(0));
        end else begin
          e = req_q.pop_front();
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", mem_addr, e.addr);
          check("mem_wmask", 32'(mem_wmask), 32'(e.wmask));
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
          check("mem_req_start_cycle", 32'(cyc), 32'(e.cyc));
        end
        ok = 1'b1; aborted = 1'b0;
        we0 = mem_we; a0 = mem_addr; w0 = mem_wdata; m0 = mem_wmask;
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (!mem_req) begin
            aborted = 1'b1;
            break;
          end
          if (mem_we !== we0 || mem_addr !== a0 || mem_wdata !== w0 ||
              mem_wmask !== m0 || busy !== 1'b1 || done !== 1'b0)
            ok = 1'b0;
        end
        if (!aborted) begin
          check("mem_req_held_stable", 32'(ok), 32'(1));
          mem_rdata = rdata_cfg;
          mem_ready = 1'b1;
          @(negedge clk);
          mem_ready = 1'b0;
          check("mem_req_dropped", 32'(mem_req), 32'(0));
        end
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (resp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check("done_fault", 32'(fault), 32'(r.fault));
        check("rd_data", rd_data, r.rd);
        check("done_cycle", 32'(cyc), 32'(r.cyc));
        check("busy_at_done", 32'(busy), 32'(0));
      end
    end
  end

  task automatic wait_done();
    int waited = 0;
    while (!done && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!done) check("done_timeout", 32'(done), 32'(1));
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int lat,
                       input logic [31:0] rdat, input logic exp_fault,
                       input logic [31:0] exp_rd, input logic [3:0] exp_mask,
                       input logic [31:0] exp_wdata, input bit extra);
    int c;
    @(negedge clk);
    lat_cfg = lat; rdata_cfg = rdat;
    is_load = ld; is_store = st; funct3 = f3; addr = a; rs2_data = d;
    start = 1'b1;
    c = cyc;
    if (!exp_fault) req_q.push_back('{st, {a[31:2], 2'b00}, exp_wdata, exp_mask, c + 1});
    resp_q.push_back('{exp_fault, exp_rd, exp_fault ? c + 1 : c + lat + 1});
    @(negedge clk);
    start = 1'b0;
    if (extra) begin
      @(negedge clk);
      start = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010;
      addr = 32'h0000_5000; rs2_data = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'b000; addr = '0; rs2_data = '0;
    #1;
    check("reset_done", 32'(done), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_fault", 32'(fault), 32'(0));
    check("reset_mem_req", 32'(mem_req), 32'(0));
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_mem_wmask", 32'(mem_wmask), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Loads
    issue(1, 0, 3'b010, 32'h0000_1004, 32'h0, 3, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b0000, 32'h0, 0);
    issue(1, 0, 3'b000, 32'h0000_1003, 32'h0, 1, 32'h80FF_0011, 0, 32'hFFFF_FF80, 4'b0000, 32'h0, 0);
    issue(1, 0, 3'b100, 32'h0000_1003, 32'h0, 2, 32'h80FF_0011, 0, 32'h0000_0080, 4'b0000, 32'h0, 0);
    issue(1, 0, 3'b001, 32'h0000_1002, 32'h0, 1, 32'h80FF_0011, 0, 32'hFFFF_80FF, 4'b0000, 32'h0, 0);
    // Stores leave rd_data alone
    issue(0, 1, 3'b000, 32'h0000_2002, 32'h1234_56AB, 2, 32'h0, 0, 32'hFFFF_80FF, 4'b0100, 32'hABAB_ABAB, 0);
    issue(0, 1, 3'b001, 32'h0000_2002, 32'h1234_56AB, 1, 32'h0, 0, 32'hFFFF_80FF, 4'b1100, 32'h56AB_56AB, 0);
    issue(0, 1, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, 1, 32'h0, 0, 32'hFFFF_80FF, 4'b1111, 32'hCAFE_F00D, 0);
    issue(1, 0, 3'b101, 32'h0000_1000, 32'h0, 1, 32'h1234_8765, 0, 32'h0000_8765, 4'b0000, 32'h0, 0);
    issue(1, 0, 3'b000, 32'h0000_1001, 32'h0, 1, 32'h0000_7F00, 0, 32'h0000_007F, 4'b0000, 32'h0, 0);
    // Faults: no memory access, rd_data unchanged
    issue(1, 0, 3'b010, 32'h0000_1002, 32'h0, 1, 32'h0, 1, 32'h0000_007F, 4'b0000, 32'h0, 0);
    issue(0, 1, 3'b001, 32'h0000_2001, 32'h0, 1, 32'h0, 1, 32'h0000_007F, 4'b0000, 32'h0, 0);
    issue(1, 1, 3'b010, 32'h0000_2000, 32'h0, 1, 32'h0, 1, 32'h0000_007F, 4'b0000, 32'h0, 0);
    issue(0, 0, 3'b010, 32'h0000_2000, 32'h0, 1, 32'h0, 1, 32'h0000_007F, 4'b0000, 32'h0, 0);
    issue(0, 1, 3'b100, 32'h0000_2000, 32'h0, 1, 32'h0, 1, 32'h0000_007F, 4'b0000, 32'h0, 0);
    issue(1, 0, 3'b011, 32'h0000_2000, 32'h0, 1, 32'h0, 1, 32'h0000_007F, 4'b0000, 32'h0, 0);
    // Start while busy is ignored; next start the cycle after done is accepted
    issue(1, 0, 3'b010, 32'h0000_3000, 32'h0, 6, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 4'b0000, 32'h0, 1);
    issue(1, 0, 3'b010, 32'h0000_3004, 32'h0, 1, 32'h1122_3344, 0, 32'h1122_3344, 4'b0000, 32'h0, 0);

    // Reset in the middle of a request
    @(negedge clk);
    lat_cfg = 10; rdata_cfg = 32'h0;
    is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_4000;
    start = 1'b1;
    req_q.push_back('{1'b0, 32'h0000_4000, 32'h0, 4'b0000, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_done", 32'(done), 32'(0));
    check("rst_mid_rd_data", rd_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(1, 0, 3'b010, 32'h0000_4008, 32'h0, 2, 32'h5566_7788, 0, 32'h5566_7788, 4'b0000, 32'h0, 0);

    repeat (5) @(negedge clk);
    check("pending_requests", 32'(req_q.size()), 32'(0));
    check("pending_completions", 32'(resp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
